ring_rr_arbiter: RTL and testbench
==================================

Name: ring_rr_arbiter

Overview:
- Round-robin arbiter for N requesters sharing one resource.
- Priority is held as a one-hot rotating ring pointer.
- The ring steps left or right under `mod`, and the pointer can be preset with `load` and `data`.
- Sits in front of a shared datapath resource. It issues one registered one-hot grant at a time, with a hold-time limit so no requester can starve the others.

Parameters:
- N, 4, number of requesters. Width of the ring pointer and the grant vector.
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay asserted.
- HOLD_W, 4, width of the hold counter. Must hold MAX_HOLD-1.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- mod  input  1  ring direction. 1 = search and rotate toward higher index (left, bit3 wraps to bit0). 0 = toward lower index (right, bit0 wraps to bit3).
- load  input  1  synchronous pointer preset strobe.
- data  input  N  one-hot value for the priority pointer.
- req  input  N  request vector, level-sensitive. req[i] must stay high for as long as i needs the resource.
- grant  output  N  one-hot grant, registered.
- busy  output  1  high while in GRANT state. Equals OR of grant.
- ptr  output  N  current one-hot priority pointer. The bit set is the highest-priority requester.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.
- load_err  output  1  one-cycle pulse when load=1 and data is not one-hot.

Behaviour:
- Reset (reset=0, asynchronous): ptr=0001 (bit0 only, any N). grant=0, busy=0, timeout=0, load_err=0, hold counter=0, state=IDLE. A grant in progress drops immediately, without waiting for a clock edge.
- State IDLE:
  - At each edge, if req != 0, the winner is the first set req bit found starting at the ptr position, searching in the direction given by `mod` with wrap-around.
  - grant <= one-hot winner, busy <= 1, hold <= 0, state <= GRANT.
  - Latency: req high before edge k gives grant high after edge k. This is one-cycle latency from a registered req sample.
  - If req == 0, IDLE stays and all outputs hold.
- State GRANT, with g = index of the current grant:
  - Release condition: req[g]==0, or hold == MAX_HOLD-1.
  - No release: hold <= hold+1. Grant stays, whatever other req bits do.
  - On release at edge k:
    - grant <= 0, busy <= 0, state <= IDLE, hold <= 0.
    - ptr <= one-hot g rotated one step in the current `mod` direction, so g becomes lowest priority.
    - timeout <= 1 for one cycle only when req[g] is still 1 (forced release).
- Gap between grants: exactly one idle cycle. The earliest next grant appears after edge k+1.
- Maximum grant length is MAX_HOLD cycles.
- Load:
  - Sampled every edge in any state.
  - If data is one-hot: ptr <= data, unless a release rotation happens at the same edge; the rotation wins and the load is dropped silently.
  - If data is not one-hot (0 or more than one bit set): ptr unchanged, load_err=1 for one cycle.
  - A load never alters an active grant.
- `mod` is sampled at each arbitration and each rotation. Changing it mid-grant only affects the next rotation.
- Invariants: grant is always 0 or one-hot. ptr is always one-hot. busy == |grant. timeout and load_err never last more than one cycle.

Test Plan:
- Reset then req=0110, mod=1, ptr=0001: grant=0010 after first edge; req[1] drops, then ptr=0100, grant=0000; next edge grant=0100.
- mod=0, ptr=0001, req=1010: grant=1000 (wrap downward); on release ptr=0100 (rotated right from 1000).
- req=0001 held high, MAX_HOLD=8: grant=0001 high for exactly 8 cycles, timeout pulses on the revoke edge, ptr=0010, one idle cycle, then grant=0001 again if no other req.
- load=1, data=1000 in IDLE, req=1001, mod=1: ptr=1000, then grant=1000. load=1, data=0110: load_err pulse, ptr unchanged.
- Release and load=1 at the same edge (granted 0010, mod=1, data=0001): ptr=0100 (rotation wins), load_err=0.
- reset asserted mid-grant between edges: grant=0000 and busy=0 immediately, ptr=0001; after deassert with req=0100, grant=0100 one edge later.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring, bounded grant hold and pointer preset.
// state | meaning
// IDLE  | no grant; arbitrate on the next edge if any req is set
// GRANT | one requester owns the resource until release or hold limit
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mod,
  input  logic         load,
  input  logic [N-1:0] data,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [N-1:0] ptr,
  output logic         timeout,
  output logic         load_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        grant_q, grant_d;
  logic [N-1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic                load_err_q, load_err_d;

  logic [IDX_W-1:0]    ptr_idx;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    win_idx;
  logic                found;
  logic                data_ok;
  logic                req_g;
  logic [N-1:0]        grant_rot;

  // Walk the ring from the pointer in the mod direction; first set req wins.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IDX_W'(i);
    end
    cand    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (mod) cand = IDX_W'((int'(ptr_idx) + k) % N);
      else     cand = IDX_W'((int'(ptr_idx) + N - k) % N);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    data_ok   = (data != '0) && ((data & (data - ONE)) == '0);
    req_g     = |(req & grant_q);
    grant_rot = mod ? {grant_q[N-2:0], grant_q[N-1]} : {grant_q[0], grant_q[N-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    load_err_d = 1'b0;

    if (load) begin
      if (data_ok) ptr_d = data;
      else         load_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = ONE << win_idx;
          hold_d  = HOLD_W'(MAX_HOLD - 1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        // hold_q counts down the remaining grant cycles; zero means the limit is reached
        if (!req_g || hold_q == '0) begin
          grant_d   = '0;
          hold_d    = '0;
          state_d   = IDLE;
          ptr_d     = grant_rot;
          timeout_d = req_g;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= ONE;
      hold_q     <= '0;
      timeout_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      load_err_q <= load_err_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == GRANT);
  assign ptr      = ptr_q;
  assign timeout  = timeout_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: directed scenarios plus random traffic against an index-based model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         mod;
  logic         load;
  logic [N-1:0] data;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         busy;
  logic [N-1:0] ptr;
  logic         timeout;
  logic         load_err;

  int n_cmp = 0;
  int n_err = 0;

  // model: pointer and grant as plain indices, hold as cycles already granted
  int m_ptr;
  int m_g;
  int m_hold;
  bit m_tmo;
  bit m_lerr;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clock(clock), .reset(reset), .mod(mod), .load(load), .data(data), .req(req),
    .grant(grant), .busy(busy), .ptr(ptr), .timeout(timeout), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_g = -1; m_hold = 0; m_tmo = 0; m_lerr = 0;
  endtask

  task automatic model_edge();
    int np, ng, nh, j;
    bit nt, nl;
    np = m_ptr; ng = m_g; nh = m_hold; nt = 0; nl = 0;
    if (load) begin
      if ($countones(data) == 1) begin
        for (int i = 0; i < N; i++) if (data[i]) np = i;
      end else nl = 1;
    end
    if (m_g < 0) begin
      for (int k = 0; k < N; k++) begin
        j = mod ? (m_ptr + k) % N : (m_ptr - k + N) % N;
        if (ng < 0 && req[j]) begin
          ng = j; nh = 0;
        end
      end
    end else if (!req[m_g] || m_hold == MAX_HOLD - 1) begin
      ng = -1; nh = 0;
      np = mod ? (m_g + 1) % N : (m_g + N - 1) % N;
      nt = req[m_g];
    end else nh = m_hold + 1;
    m_ptr = np; m_g = ng; m_hold = nh; m_tmo = nt; m_lerr = nl;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = (m_g < 0) ? '0 : (N'(1) << m_g);
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_g >= 0));
    chk("ptr", 32'(ptr), 32'(N'(1) << m_ptr));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("load_err", 32'(load_err), 32'(m_lerr));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    reset = 1'b0; mod = 1'b1; load = 1'b0; data = '0; req = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;

    // left search from bit0, release on req drop, one idle cycle, next grant
    req = 4'b0110; mod = 1'b1;
    step(); chk("t1_grant", 32'(grant), 32'h2);
    req = 4'b0100;
    step(); chk("t1_ptr", 32'(ptr), 32'h4); chk("t1_gap", 32'(grant), 32'h0);
    step(); chk("t1_grant2", 32'(grant), 32'h4);
    req = '0;
    step();

    // right search wraps downward
    load = 1'b1; data = 4'b0001;
    step();
    load = 1'b0; mod = 1'b0; req = 4'b1010;
    step(); chk("t2_grant", 32'(grant), 32'h8);
    req = '0;
    step(); chk("t2_ptr", 32'(ptr), 32'h4);

    // hold limit
    load = 1'b1; data = 4'b0001;
    step();
    load = 1'b0; mod = 1'b1; req = 4'b0001;
    step();
    cnt = (grant == 4'b0001) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant == 4'b0001) cnt++;
      else break;
    end
    chk("t3_hold_len", 32'(cnt), 32'(MAX_HOLD));
    chk("t3_timeout", 32'(timeout), 32'h1);
    chk("t3_ptr", 32'(ptr), 32'h2);
    step(); chk("t3_regrant", 32'(grant), 32'h1); chk("t3_tmo_pulse", 32'(timeout), 32'h0);
    req = '0;
    step();

    // load preset and illegal load
    load = 1'b1; data = 4'b1000;
    step(); chk("t4_ptr", 32'(ptr), 32'h8);
    load = 1'b0; req = 4'b1001;
    step(); chk("t4_grant", 32'(grant), 32'h8);
    load = 1'b1; data = 4'b0110;
    step(); chk("t4_lerr", 32'(load_err), 32'h1); chk("t4_ptr_kept", 32'(ptr), 32'h8);
    load = 1'b0;
    step(); chk("t4_lerr_pulse", 32'(load_err), 32'h0);
    req = '0;
    step();

    // release and load at the same edge: rotation wins
    req = 4'b0010;
    step(); chk("t5_grant", 32'(grant), 32'h2);
    req = '0; load = 1'b1; data = 4'b0001;
    step(); chk("t5_ptr", 32'(ptr), 32'h4); chk("t5_lerr", 32'(load_err), 32'h0);
    load = 1'b0;

    // asynchronous reset mid-grant
    req = 4'b0001;
    step(); chk("t6_grant", 32'(grant), 32'h1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_ptr", 32'(ptr), 32'h1);
    #2 reset = 1'b1; req = 4'b0100;
    step(); chk("t6_after", 32'(grant), 32'h4);
    req = '0;
    step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req  = N'($urandom);
      mod  = 1'($urandom);
      load = ($urandom_range(0, 9) == 0);
      data = N'($urandom);
      if ($urandom_range(0, 3) != 0 && m_g >= 0) req[m_g] = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
